// File: rtl/pipeline_uart_pkg.sv
// Shared UART definitions: FSM state encodings, default timing parameters and the
// 3-sample majority helper. Used by both the receiver and the transmitter.
package pipeline_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // 50 MHz / (9600 baud * 64) ~= 81
  localparam int DEF_OVERSAMPLE      = 64;
  localparam int DEF_CLKS_PER_SAMPLE = 81;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pipeline_uart_baud_tick.sv
// Free-running sample-tick generator: tick is high for one clk every
// CLKS_PER_SAMPLE clks, when the counter sits at its maximum.
module pipeline_uart_baud_tick
  import pipeline_uart_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = DEF_CLKS_PER_SAMPLE
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pipeline_uart_receiver.sv
// 8N1 LSB-first UART receiver: oversampled, mid-bit 3-sample majority vote,
// start/stop validation, one-clk RX_STATUS / RX_ERR pulses.
module pipeline_uart_receiver
  import pipeline_uart_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = DEF_CLKS_PER_SAMPLE,
  parameter int OVERSAMPLE      = DEF_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       RX_ERR
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] SC_PRE  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] SC_DEC  = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] SC_ONE  = SCW'(1);

  logic            tick;
  logic            rx_meta, rx_s, rx_p;
  logic            samp_a, samp_b, vote;
  uart_state_e     state_q, state_d;
  logic [SCW-1:0]  sc_q, sc_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_d;
  logic            status_d, err_d;

  pipeline_uart_baud_tick #(
    .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Idle-high line: sync and previous-sample flops reset to 1 so release
  // from reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_p    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
      if (tick) begin
        rx_p <= rx_s;
      end
    end
  end

  // First two votes are captured at sc=H-1 and sc=H; the third is rx_s live on the decision tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
    end else if (tick && (state_q != ST_IDLE)) begin
      if (sc_q == SC_PRE) samp_a <= rx_s;
      if (sc_q == SC_MID) samp_b <= rx_s;
    end
  end

  assign vote = maj3(samp_a, samp_b, rx_s);

  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = RX_DATA;
    status_d = 1'b0;
    err_d    = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          sc_d = '0;
          if (rx_p && !rx_s) state_d = ST_START;
        end
        ST_START: begin
          if ((sc_q == SC_DEC) && vote) begin
            state_d = ST_IDLE;
            sc_d    = '0;
          end else if (sc_q == SC_LAST) begin
            state_d = ST_DATA;
            sc_d    = '0;
            bit_d   = 3'd0;
          end else begin
            sc_d = sc_q + SC_ONE;
          end
        end
        ST_DATA: begin
          if (sc_q == SC_DEC) shift_d = {vote, shift_q[7:1]};
          if (sc_q == SC_LAST) begin
            sc_d  = '0;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = ST_STOP;
          end else begin
            sc_d = sc_q + SC_ONE;
          end
        end
        ST_STOP: begin
          // Leave mid-stop so a start edge right after the stop bit is caught.
          if (sc_q == SC_DEC) begin
            if (vote) begin
              data_d   = shift_q;
              status_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = ST_IDLE;
            sc_d    = '0;
          end else begin
            sc_d = sc_q + SC_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          sc_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sc_q      <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      RX_DATA   <= 8'h00;
      RX_STATUS <= 1'b0;
      RX_ERR    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sc_q      <= sc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      RX_DATA   <= data_d;
      RX_STATUS <= status_d;
      RX_ERR    <= err_d;
    end
  end

endmodule

// File: tb/tb_pipeline_uart_receiver.sv
// Scoreboard bench for pipeline_uart_receiver with a fast baud (bit period = 64 clk).
module tb_pipeline_uart_receiver;

  localparam int CPS      = 4;
  localparam int OS       = 16;
  localparam int BIT_CLKS = CPS * OS;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rx_err;

  int checks = 0;
  int failures = 0;
  longint cyc = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  longint     pulse_cyc[$];
  logic [7:0] last_good = 8'h00;

  pipeline_uart_receiver #(
    .CLKS_PER_SAMPLE(CPS),
    .OVERSAMPLE     (OS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .UART_RX  (uart_rx),
    .RX_DATA  (rx_data),
    .RX_STATUS(rx_status),
    .RX_ERR   (rx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Output monitor: every pulse pops one expected event.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && (rx_status || rx_err)) begin
      chk("status_err_exclusive", 32'(rx_status & rx_err), 32'd0);
      if (rx_status) pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind_err", 32'(rx_err), 32'(e.is_err));
        chk("rx_data", 32'(rx_data), 32'(e.data));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame. glitch_bit>=0 inverts that data bit for one tick at mid-bit;
  // rst_mid pulses reset in the middle of data bit 4.
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input int glitch_bit, input bit rst_mid);
    logic [9:0] fr;
    fr = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < BIT_CLKS; k++) begin
        @(negedge clk);
        uart_rx = fr[i];
        if (glitch_bit >= 0 && i == glitch_bit + 1 &&
            k >= BIT_CLKS / 2 && k < BIT_CLKS / 2 + CPS)
          uart_rx = ~fr[i];
        if (rst_mid && i == 5 && k == BIT_CLKS / 2) begin
          reset = 1'b0;
          #1;
          chk("midrst_rx_data", 32'(rx_data), 32'h00);
          chk("midrst_rx_status", 32'(rx_status), 32'd0);
          chk("midrst_rx_err", 32'(rx_err), 32'd0);
          last_good = 8'h00;
        end
        if (rst_mid && i == 5 && k == BIT_CLKS / 2 + 3) reset = 1'b1;
      end
    end
  endtask

  task automatic expect_good(input logic [7:0] b);
    exp_q.push_back('{is_err: 1'b0, data: b});
    last_good = b;
  endtask

  initial begin
    longint gap;
    idle(5);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rx_status", 32'(rx_status), 32'd0);
    chk("reset_rx_err", 32'(rx_err), 32'd0);
    reset = 1'b1;
    idle(20);

    expect_good(8'h55);
    send_frame(8'h55, 1'b1, -1, 1'b0);
    idle(BIT_CLKS);

    // Bad stop: error pulse, data register keeps the previous good byte.
    exp_q.push_back('{is_err: 1'b1, data: last_good});
    send_frame(8'hA3, 1'b0, -1, 1'b0);
    idle(2 * BIT_CLKS);
    uart_rx = 1'b1;
    idle(3 * BIT_CLKS);

    // Short low glitch on an idle line is rejected in START.
    uart_rx = 1'b0;
    idle(3 * CPS);
    uart_rx = 1'b1;
    idle(2 * BIT_CLKS);
    expect_good(8'hA3);
    send_frame(8'hA3, 1'b1, -1, 1'b0);
    idle(BIT_CLKS);

    // Back-to-back frames: pulses exactly one frame (10 bit periods) apart.
    pulse_cyc.delete();
    expect_good(8'h00);
    expect_good(8'hFF);
    send_frame(8'h00, 1'b1, -1, 1'b0);
    send_frame(8'hFF, 1'b1, -1, 1'b0);
    idle(BIT_CLKS);
    chk("b2b_pulse_count", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2) begin
      gap = pulse_cyc[1] - pulse_cyc[0];
      chk("b2b_gap_in_range", 32'(gap >= FRAME_CLKS - 2 && gap <= FRAME_CLKS + 2), 32'd1);
    end

    expect_good(8'h0F);
    send_frame(8'h0F, 1'b1, 2, 1'b0);
    idle(BIT_CLKS);

    // 0xF0 keeps the line high from bit 4 on, so no stray edge follows the reset.
    send_frame(8'hF0, 1'b1, -1, 1'b1);
    idle(3 * BIT_CLKS);
    expect_good(8'h3C);
    send_frame(8'h3C, 1'b1, -1, 1'b0);
    idle(2 * BIT_CLKS);

    chk("pending_expected_events", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
